// File: rtl/debug_pkg.sv
// Shared constants, FSM encoding and frame sizing for the pipeline debug unit.
// DEBUG_CYCLE_COUNT_EN appends a 32-bit enabled-cycle counter word to every frame.
package debug_pkg;

  localparam logic [7:0] DBG_CMD_RUN  = 8'h63;
  localparam logic [7:0] DBG_CMD_STEP = 8'h73;
  localparam logic [7:0] DBG_CMD_READ = 8'h72;

  localparam logic [5:0] DBG_HALT_OPCODE = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_SEND_LOAD,
    ST_SEND_WAIT
  } dbg_state_t;

  function automatic int frame_bytes(input int nwords);
`ifdef DEBUG_CYCLE_COUNT_EN
    return 4 * (nwords + 1);
`else
    return 4 * nwords;
`endif
  endfunction

endpackage

// File: rtl/debug_tx_serializer.sv
// Byte index counter and byte mux over the snapshot (plus cycle count word
// when DEBUG_CYCLE_COUNT_EN is defined); word 0 first, LSB byte first.
module debug_tx_serializer
  import debug_pkg::*;
#(
  parameter int NWORDS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic [32*NWORDS-1:0]  snapshot,
`ifdef DEBUG_CYCLE_COUNT_EN
  input  logic [31:0]           cycle_count,
`endif
  output logic [7:0]            tx_byte,
  output logic                  last
);

  localparam int FB = frame_bytes(NWORDS);
  localparam int IW = $clog2(FB);

  logic [IW-1:0]   idx;
  logic [8*FB-1:0] frame;

`ifdef DEBUG_CYCLE_COUNT_EN
  assign frame = {cycle_count, snapshot};
`else
  assign frame = snapshot;
`endif

  assign last    = (idx == IW'(FB - 1));
  // base built by concatenation so the byte offset is not truncated to IW bits
  assign tx_byte = frame[{idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (advance) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/debug_unit.sv
// Host debug controller: UART commands gate the pipeline enable, then the
// snapshot is streamed back byte by byte. DEBUG_CYCLE_COUNT_EN adds a count word.
//
// state        | meaning
// IDLE         | waiting for a command byte
// RUN          | pipeline enabled until the halt opcode is fetched
// STEP         | pipeline enabled for a single cycle
// SEND_LOAD    | present next frame byte and pulse tx_start
// SEND_WAIT    | hold the byte until the UART reports tx_done
module debug_unit
  import debug_pkg::*;
#(
  parameter int          NWORDS      = 8,
  parameter logic [5:0]  HALT_OPCODE = DBG_HALT_OPCODE,
  parameter logic [7:0]  CMD_RUN     = DBG_CMD_RUN,
  parameter logic [7:0]  CMD_STEP    = DBG_CMD_STEP,
  parameter logic [7:0]  CMD_READ    = DBG_CMD_READ
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  input  logic                  tx_done,
  input  logic [32*NWORDS-1:0]  snapshot,
  input  logic [31:0]           instruction_IF,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  pipe_en,
  output logic                  halted,
  output logic                  busy
);

  dbg_state_t state;
  logic       halt_seen;
  logic       advance;
  logic [7:0] ser_byte;
  logic       ser_last;
  logic       unused_instr;

  assign halt_seen    = (instruction_IF[31:26] == HALT_OPCODE);
  assign unused_instr = ^instruction_IF[25:0];
  assign busy         = (state != ST_IDLE);
  assign advance      = (state == ST_SEND_WAIT) && tx_done;

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] cycle_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (pipe_en) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

  debug_tx_serializer #(
    .NWORDS(NWORDS)
  ) u_ser (
    .clk        (clk),
    .reset      (reset),
    .advance    (advance),
    .snapshot   (snapshot),
`ifdef DEBUG_CYCLE_COUNT_EN
    .cycle_count(cycle_count),
`endif
    .tx_byte    (ser_byte),
    .last       (ser_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      pipe_en  <= 1'b0;
      halted   <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_done) begin
            if (rx_data == CMD_RUN && !halted) begin
              state   <= ST_RUN;
              pipe_en <= 1'b1;
            end else if (rx_data == CMD_STEP && !halted) begin
              state   <= ST_STEP;
              pipe_en <= 1'b1;
            end else if (rx_data == CMD_READ || rx_data == CMD_RUN ||
                         rx_data == CMD_STEP) begin
              state <= ST_SEND_LOAD;
            end
          end
        end
        ST_RUN: begin
          // the halting fetch is still clocked into the pipeline this cycle
          if (pipe_en && halt_seen) begin
            pipe_en <= 1'b0;
            halted  <= 1'b1;
            state   <= ST_SEND_LOAD;
          end
        end
        ST_STEP: begin
          pipe_en <= 1'b0;
          if (halt_seen) halted <= 1'b1;
          state <= ST_SEND_LOAD;
        end
        ST_SEND_LOAD: begin
          tx_data  <= ser_byte;
          tx_start <= 1'b1;
          state    <= ST_SEND_WAIT;
        end
        ST_SEND_WAIT: begin
          if (tx_done) state <= ser_last ? ST_IDLE : ST_SEND_LOAD;
        end
        default: begin
          state   <= ST_IDLE;
          pipe_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
